// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer: SB_RGBA_DRV power-up sequencing and per-channel static/fade/blink PWM
// Config words are double-buffered and take effect on a PWM period boundary while running.
module rgb_pwm_sequencer #(
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_W    = 16,
  parameter int PWR_UP_CYCLES = 16
) (
  input  logic                  hw_clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [PWM_BITS-1:0]   cfg_r,
  input  logic [PWM_BITS-1:0]   cfg_g,
  input  logic [PWM_BITS-1:0]   cfg_b,
  input  logic [1:0]            cfg_mode,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  output logic                  pwm_r,
  output logic                  pwm_g,
  output logic                  pwm_b,
  output logic                  curr_en,
  output logic                  led_en,
  output logic                  busy,
  output logic                  period_tick
);
  localparam int N  = PWM_BITS;
  localparam int CW = $clog2(PWR_UP_CYCLES + 1);
  localparam logic [N-1:0]  MAX     = '1;
  localparam logic [CW-1:0] SC_LAST = CW'(PWR_UP_CYCLES - 1);

  typedef enum logic [1:0] {OFF, STARTUP, RUN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         sc_q, sc_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d, pre_q, pre_d, sh_pre_q;
  logic [N-1:0]          cnt_q, cnt_d, lvl_q, lvl_d;
  logic [N-1:0]          r_q, r_d, g_q, g_d, b_q, b_d, sh_r_q, sh_g_q, sh_b_q;
  logic [1:0]            mode_q, mode_d, sh_mode_q;
  logic                  up_q, up_d, pend_q, pend_d;
  logic                  run, tick, wrap, apply, accept;
  logic                  pwm_r_q, pwm_g_q, pwm_b_q, on_q, led_q, pt_q;

  function automatic logic [N-1:0] eff(input logic [N-1:0] d, l, input logic [1:0] m);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, d} * {{N{1'b0}}, l};
    return (m == 2'd1) ? p[2*N-1:N] : (m == 2'd2 && l == '0) ? '0 : d;
  endfunction

  always_comb begin
    run     = state_q == RUN && en;
    tick    = presc_q == pre_q;
    wrap    = run && tick && cnt_q == MAX;
    apply   = pend_q && (state_q != RUN || wrap);
    accept  = cfg_valid && !pend_q;
    state_d = !en ? OFF : state_q == OFF ? STARTUP :
              (state_q == STARTUP && sc_q != SC_LAST) ? STARTUP : RUN;
    sc_d    = (state_q == STARTUP && state_d == STARTUP) ? sc_q + 1'b1 : '0;
    presc_d = (run && !tick) ? presc_q + 1'b1 : '0;
    cnt_d   = run ? cnt_q + N'(tick) : '0;
    {r_d, g_d, b_d, mode_d, pre_d} = apply ? {sh_r_q, sh_g_q, sh_b_q, sh_mode_q, sh_pre_q}
                                           : {r_q, g_q, b_q, mode_q, pre_q};
    pend_d  = accept || (pend_q && !apply);
    lvl_d   = lvl_q;
    up_d    = up_q;
    // a mode change restarts the fade/blink pattern from dark
    if (!run || (wrap && mode_d != mode_q)) begin
      lvl_d = '0;
      up_d  = 1'b1;
    end else if (wrap && mode_q == 2'd1) begin
      lvl_d = up_q ? lvl_q + 1'b1 : lvl_q - 1'b1;
      up_d  = up_q ? (lvl_q != MAX - 1'b1) : (lvl_q == N'(1));
    end else if (wrap && mode_q == 2'd2) begin
      lvl_d = (lvl_q == '0) ? MAX : '0;
    end
  end

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      state_q   <= OFF;
      sc_q      <= '0;
      presc_q   <= '0;
      cnt_q     <= '0;
      lvl_q     <= '0;
      up_q      <= 1'b1;
      pend_q    <= 1'b0;
      {r_q, g_q, b_q, mode_q, pre_q} <= '0;
      {sh_r_q, sh_g_q, sh_b_q, sh_mode_q, sh_pre_q} <= '0;
      {pwm_r_q, pwm_g_q, pwm_b_q, on_q, led_q, pt_q} <= '0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      up_q      <= up_d;
      pend_q    <= pend_d;
      {r_q, g_q, b_q, mode_q, pre_q} <= {r_d, g_d, b_d, mode_d, pre_d};
      if (accept) {sh_r_q, sh_g_q, sh_b_q, sh_mode_q, sh_pre_q} <= {cfg_r, cfg_g, cfg_b, cfg_mode, cfg_prescale};
      pwm_r_q   <= state_d == RUN && cnt_d < eff(r_d, lvl_d, mode_d);
      pwm_g_q   <= state_d == RUN && cnt_d < eff(g_d, lvl_d, mode_d);
      pwm_b_q   <= state_d == RUN && cnt_d < eff(b_d, lvl_d, mode_d);
      on_q      <= state_d != OFF;
      led_q     <= state_d == RUN;
      pt_q      <= state_d == RUN && cnt_d == MAX && presc_d == pre_d;
    end
  end

  assign cfg_ready   = !pend_q;
  assign pwm_r       = pwm_r_q;
  assign pwm_g       = pwm_g_q;
  assign pwm_b       = pwm_b_q;
  assign curr_en     = on_q;
  assign busy        = on_q;
  assign led_en      = led_q;
  assign period_tick = pt_q;
endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb_rgb_pwm_sequencer: randomized scoreboard bench for rgb_pwm_sequencer
// The reference model tracks time in ticks and wraps; fade level is a triangle wave of the wrap count.
module tb_rgb_pwm_sequencer;
  logic        hw_clk = 1'b0, rst = 1'b1, en = 1'b0, cfg_valid = 1'b0;
  logic [7:0]  cfg_r = '0, cfg_g = '0, cfg_b = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_prescale = '0;
  logic        cfg_ready, pwm_r, pwm_g, pwm_b, curr_en, led_en, busy, period_tick;

  always #5 hw_clk = ~hw_clk;

  rgb_pwm_sequencer dut (
    .hw_clk(hw_clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_r(cfg_r), .cfg_g(cfg_g), .cfg_b(cfg_b), .cfg_mode(cfg_mode), .cfg_prescale(cfg_prescale),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .curr_en(curr_en), .led_en(led_en),
    .busy(busy), .period_tick(period_tick)
  );

  logic [7:0] exp_q[$];
  logic [7:0] e_v, a_v;
  int n_chk = 0, n_pass = 0;

  // phase: 0 off, 1 powering up, 2 running
  int ph, su, pc, cnt, w, pend;
  int ar, ag, ab, am, ap, sr, sg, sb, sm, sp;

  task automatic m_reset();
    ph = 0; su = 0; pc = 0; cnt = 0; w = 0; pend = 0;
    ar = 0; ag = 0; ab = 0; am = 0; ap = 0;
    sr = 0; sg = 0; sb = 0; sm = 0; sp = 0;
  endtask

  function automatic int m_lvl();
    int k;
    k = w % 510;
    if (am == 1) return (k <= 255) ? k : 510 - k;
    if (am == 2) return (w % 2 == 1) ? 255 : 0;
    return 0;
  endfunction

  function automatic int m_eff(int d);
    int l;
    l = m_lvl();
    if (am == 1) return (d * l) / 256;
    if (am == 2 && l == 0) return 0;
    return d;
  endfunction

  function automatic logic [7:0] m_out();
    logic [7:0] o;
    o[7] = (pend == 0);
    o[6] = (ph == 2) && (cnt < m_eff(ar));
    o[5] = (ph == 2) && (cnt < m_eff(ag));
    o[4] = (ph == 2) && (cnt < m_eff(ab));
    o[3] = (ph != 0);
    o[2] = (ph == 2);
    o[1] = (ph != 0);
    o[0] = (ph == 2) && (cnt == 255) && (pc == ap);
    return o;
  endfunction

  task automatic m_step();
    int run, tick, wrap, apply, acc, nph;
    if (rst) begin
      m_reset();
    end else begin
      run   = (ph == 2) && en;
      tick  = (pc == ap);
      wrap  = run && tick && (cnt == 255);
      apply = pend && ((ph != 2) || wrap);
      acc   = cfg_valid && !pend;
      nph   = !en ? 0 : (ph == 0) ? 1 : (ph == 1) ? ((su == 15) ? 2 : 1) : 2;
      su    = (ph == 1 && nph == 1) ? su + 1 : 0;
      pc    = run ? (tick ? 0 : pc + 1) : 0;
      cnt   = run ? (cnt + tick) % 256 : 0;
      if (!run) w = 0;
      else if (wrap) w = (apply && sm != am) ? 0 : w + 1;
      if (apply) begin ar = sr; ag = sg; ab = sb; am = sm; ap = sp; end
      if (acc) begin sr = cfg_r; sg = cfg_g; sb = cfg_b; sm = cfg_mode; sp = cfg_prescale; end
      pend  = acc ? 1 : apply ? 0 : pend;
      ph    = nph;
    end
  endtask

  task automatic cyc();
    @(posedge hw_clk);
    m_step();
    exp_q.push_back(m_out());
    #1;
  endtask

  task automatic write(input int r, g, b, mode, pre);
    cfg_r = 8'(r); cfg_g = 8'(g); cfg_b = 8'(b); cfg_mode = 2'(mode); cfg_prescale = 16'(pre);
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 2000 && pend != 0; i++) cyc();
    if (pend != 0) begin
      n_chk++;
      $display("FAIL wait_ready: pending still %0d, required 0", pend);
    end
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 600 && !(ph == 2 && cnt == v); i++) cyc();
    if (!(ph == 2 && cnt == v)) begin
      n_chk++;
      $display("FAIL wait_cnt: cnt %0d phase %0d, required cnt %0d in run", cnt, ph, v);
    end
  endtask

  always @(negedge hw_clk) begin
    if (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      a_v = {cfg_ready, pwm_r, pwm_g, pwm_b, curr_en, led_en, busy, period_tick};
      n_chk++;
      if (a_v === e_v) n_pass++;
      else $display("FAIL outputs @%0t got %b want %b (ready,r,g,b,curr,led,busy,ptick)", $time, a_v, e_v);
    end
  end

  initial begin
    int d;
    m_reset();
    repeat (3) cyc();
    rst = 1'b0;
    en = 1'b1;
    repeat (20) cyc();
    write(64, 0, 255, 0, 0);
    repeat (600) cyc();
    wait_cnt(100);
    write(200, 0, 255, 0, 0);
    cfg_valid = 1'b1;
    cfg_r = 8'd17;
    repeat (10) cyc();
    cfg_valid = 1'b0;
    repeat (400) cyc();
    wait_ready();
    write(64, 0, 255, 0, 3);
    repeat (2100) cyc();
    wait_ready();
    write(255, 128, 7, 1, 0);
    repeat (260 * 256) cyc();
    wait_ready();
    write(200, 0, 90, 2, 0);
    repeat (1100) cyc();
    for (int i = 0; i < 3000; i++) begin
      cfg_valid = ($urandom_range(0, 7) == 0);
      d = $urandom_range(0, 2);
      cfg_r = (d == 0) ? 8'd0 : (d == 1) ? 8'd255 : 8'($urandom);
      cfg_g = 8'($urandom);
      cfg_b = 8'($urandom);
      cfg_mode = 2'($urandom);
      cfg_prescale = 16'($urandom_range(0, 2));
      en = ($urandom_range(0, 299) != 0);
      cyc();
    end
    cfg_valid = 1'b0;
    en = 1'b1;
    wait_ready();
    write(90, 180, 30, 0, 0);
    repeat (60) cyc();
    en = 1'b0;
    repeat (5) cyc();
    en = 1'b1;
    repeat (60) cyc();
    write(10, 20, 30, 1, 1);
    rst = 1'b1;
    exp_q.delete();
    m_reset();
    exp_q.push_back(m_out());
    repeat (2) cyc();
    rst = 1'b0;
    repeat (40) cyc();
    @(negedge hw_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
